// File: rtl/leve2_id_stage.sv
`default_nettype none
// leve2_id_stage: decode/register-read stage with EX/WB operand forwarding,
// load-use bubble insertion, valid/ready backpressure and an out-of-range register flag.
module leve2_id_stage #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IF_VALID,
  output logic             IF_READY,
  input  logic [XLEN-1:0]  IF_PC,
  input  logic [31:0]      IF_INSTR,
  input  logic             FLUSH,
  output logic             ID_VALID,
  input  logic             ID_READY,
  output logic [XLEN-1:0]  ID_PC,
  output logic [31:0]      ID_INSTR,
  output logic [XLEN-1:0]  ID_RS1,
  output logic [XLEN-1:0]  ID_RS2,
  output logic             ID_ILL,
  input  logic [XLEN-1:0]  EX_FWD_DATA,
  input  logic             WB_WE,
  input  logic [4:0]       WB_RD,
  input  logic [XLEN-1:0]  WB_DATA,
  output logic [CNT_W-1:0] HAZ_CNT
);

  localparam int         IDX_W  = $clog2(NREG);
  localparam logic [5:0] NREG_L = 6'(NREG);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic rd_used(input logic [6:0] op);
    return (op != OP_BRANCH) && (op != OP_STORE);
  endfunction

  function automatic logic rs1_used(input logic [6:0] op);
    return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP) || (op == OP_AMO);
  endfunction

  function automatic logic out_of_range(input logic [4:0] idx);
    return {1'b0, idx} >= NREG_L;
  endfunction

  // First match wins: x0, out-of-range, EX forward, WB bypass, register file.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic            used,
    input logic [4:0]      rs,
    input logic            fwd_ok,
    input logic [4:0]      fwd_rd,
    input logic [XLEN-1:0] fwd_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data,
    input logic [XLEN-1:0] rf_data
  );
    if (!used || rs == 5'd0 || out_of_range(rs)) return '0;
    if (fwd_ok && fwd_rd == rs)                  return fwd_data;
    if (wb_we && wb_rd == rs)                    return wb_data;
    return rf_data;
  endfunction

  logic [XLEN-1:0] regs [NREG];

  logic [6:0]      held_op;
  logic [4:0]      held_rd;
  logic [6:0]      if_op;
  logic [4:0]      if_rd;
  logic [4:0]      if_rs1;
  logic [4:0]      if_rs2;
  logic            use_rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            held_is_load;
  logic            held_fwd_ok;
  logic            adv;
  logic            hazard;
  logic            ill;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;
  logic [XLEN-1:0] op_rs1;
  logic [XLEN-1:0] op_rs2;

  assign held_op      = ID_INSTR[6:0];
  assign held_rd      = ID_INSTR[11:7];
  assign if_op        = IF_INSTR[6:0];
  assign if_rd        = IF_INSTR[11:7];
  assign if_rs1       = IF_INSTR[19:15];
  assign if_rs2       = IF_INSTR[24:20];

  assign use_rd       = rd_used(if_op);
  assign use_rs1      = rs1_used(if_op);
  assign use_rs2      = rs2_used(if_op);

  assign held_is_load = (held_op == OP_LOAD);
  // A held load has no result yet in EX, so it never feeds the forward path.
  assign held_fwd_ok  = ID_VALID && !held_is_load && rd_used(held_op);

  assign adv    = !ID_VALID || ID_READY;
  assign hazard = ID_VALID && IF_VALID && held_is_load && (held_rd != 5'd0) &&
                  ((use_rs1 && if_rs1 == held_rd) || (use_rs2 && if_rs2 == held_rd));

  assign IF_READY = FLUSH || (adv && !hazard);

  assign rf_rs1 = regs[if_rs1[IDX_W-1:0]];
  assign rf_rs2 = regs[if_rs2[IDX_W-1:0]];

  assign op_rs1 = sel_operand(use_rs1, if_rs1, held_fwd_ok, held_rd, EX_FWD_DATA,
                              WB_WE, WB_RD, WB_DATA, rf_rs1);
  assign op_rs2 = sel_operand(use_rs2, if_rs2, held_fwd_ok, held_rd, EX_FWD_DATA,
                              WB_WE, WB_RD, WB_DATA, rf_rs2);

  assign ill = (use_rs1 && out_of_range(if_rs1)) ||
               (use_rs2 && out_of_range(if_rs2)) ||
               (use_rd  && out_of_range(if_rd));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ID_VALID <= 1'b0;
      ID_PC    <= '0;
      ID_INSTR <= '0;
      ID_RS1   <= '0;
      ID_RS2   <= '0;
      ID_ILL   <= 1'b0;
    end else if (FLUSH) begin
      ID_VALID <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        ID_VALID <= 1'b0;
      end else begin
        ID_VALID <= IF_VALID;
        ID_PC    <= IF_PC;
        ID_INSTR <= IF_INSTR;
        ID_RS1   <= op_rs1;
        ID_RS2   <= op_rs2;
        ID_ILL   <= ill;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HAZ_CNT <= '0;
    end else if (hazard && adv && !FLUSH && (HAZ_CNT != {CNT_W{1'b1}})) begin
      HAZ_CNT <= HAZ_CNT + 1'b1;
    end
  end

  // The register file has no reset; writes are gated off while reset is held.
  always_ff @(posedge CLK) begin
    if (!RST && WB_WE && (WB_RD != 5'd0) && !out_of_range(WB_RD)) begin
      regs[WB_RD[IDX_W-1:0]] <= WB_DATA;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leve2_id_stage.sv
`default_nettype none
// tb_leve2_id_stage: table-driven vectors plus hand-written hazard, backpressure,
// flush, reset and NREG=16 sequences, checked through an expected-output queue.
module tb_leve2_id_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_VALID = 1'b0;
  logic [31:0] IF_PC = '0;
  logic [31:0] IF_INSTR = '0;
  logic        FLUSH = 1'b0;
  logic        ID_READY = 1'b1;
  logic [31:0] EX_FWD_DATA = '0;
  logic        WB_WE = 1'b0;
  logic [4:0]  WB_RD = '0;
  logic [31:0] WB_DATA = '0;

  logic        IF_READY, ID_VALID, ID_ILL;
  logic [31:0] ID_PC, ID_INSTR, ID_RS1, ID_RS2;
  logic [15:0] HAZ_CNT;

  logic        rdy1, vld1, ill1;
  logic [31:0] pc1, ins1, rs1_1, rs2_1;
  logic [1:0]  haz1;

  leve2_id_stage #(.XLEN(32), .NREG(32), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_PC(IF_PC),
    .IF_INSTR(IF_INSTR), .FLUSH(FLUSH), .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_PC(ID_PC), .ID_INSTR(ID_INSTR), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_ILL(ID_ILL),
    .EX_FWD_DATA(EX_FWD_DATA), .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .HAZ_CNT(HAZ_CNT)
  );

  leve2_id_stage #(.XLEN(32), .NREG(16), .CNT_W(2)) dut16 (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_READY(rdy1), .IF_PC(IF_PC),
    .IF_INSTR(IF_INSTR), .FLUSH(FLUSH), .ID_VALID(vld1), .ID_READY(ID_READY),
    .ID_PC(pc1), .ID_INSTR(ins1), .ID_RS1(rs1_1), .ID_RS2(rs2_1), .ID_ILL(ill1),
    .EX_FWD_DATA(EX_FWD_DATA), .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .HAZ_CNT(haz1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic [31:0] fwd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eill;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[10];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] pc = 32'h1000;
  string       tag = "reset";

  function automatic logic [31:0] mk(input int f7, input int rs2, input int rs1,
                                     input int f3, input int rd, input int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s/%s actual=%h required=%h", tag, nm, act, req);
    end
  endtask

  // One cycle: drive, check IF_READY, update the expected queue, clock, check ID outputs.
  task automatic tick(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic [31:0] fwd, input logic er, input logic psh,
                      input logic [31:0] e1, input logic [31:0] e2, input logic eill);
    IF_VALID = v; IF_INSTR = ins; IF_PC = pc; ID_READY = rdy; FLUSH = fl;
    WB_WE = we; WB_RD = wrd; WB_DATA = wdat; EX_FWD_DATA = fwd;
    #1;
    chk("if_ready", {31'd0, IF_READY}, {31'd0, er});
    if (q.size() > 0 && (rdy || fl)) void'(q.pop_front());
    if (psh) begin
      q.push_back('{pc, ins, e1, e2, eill});
      pc += 32'd4;
    end
    @(posedge CLK); #1;
    chk("id_valid", {31'd0, ID_VALID}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("id_pc",    ID_PC,    q[0].pc);
      chk("id_instr", ID_INSTR, q[0].ins);
      chk("id_rs1",   ID_RS1,   q[0].r1);
      chk("id_rs2",   ID_RS2,   q[0].r2);
      chk("id_ill",   {31'd0, ID_ILL}, {31'd0, q[0].ill});
    end
  endtask

  task automatic wb_only(input logic [4:0] rd, input logic [31:0] d);
    tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, rd, d, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // instr, we, wrd, wdat, fwd, exp_rs1, exp_rs2, exp_ill
    tbl[0] = '{mk(0, 2, 1, 0, 7, 'h33),   1'b0, 5'd0,  32'h0,    32'hF0,   32'h11,   32'h22,  1'b0};
    tbl[1] = '{mk(0, 3, 7, 0, 8, 'h33),   1'b0, 5'd0,  32'h0,    32'h777,  32'h777,  32'h33,  1'b0};
    tbl[2] = '{mk(0, 8, 5, 2, 7, 'h23),   1'b0, 5'd0,  32'h0,    32'h888,  32'h55,   32'h888, 1'b0};
    tbl[3] = '{mk(0, 10, 7, 0, 9, 'h33),  1'b0, 5'd0,  32'h0,    32'hDEAD, 32'h70,   32'hAA,  1'b0};
    tbl[4] = '{mk(0, 0, 2, 0, 11, 'h33),  1'b1, 5'd2,  32'h222,  32'hF4,   32'h222,  32'h0,   1'b0};
    tbl[5] = '{mk(0, 0, 11, 0, 12, 'h37), 1'b0, 5'd0,  32'h0,    32'hBAD,  32'h0,    32'h0,   1'b0};
    tbl[6] = '{mk(0, 2, 12, 0, 3, 'h63),  1'b0, 5'd0,  32'h0,    32'h1200, 32'h1200, 32'h222, 1'b0};
    tbl[7] = '{mk(0, 1, 3, 0, 13, 'h33),  1'b0, 5'd0,  32'h0,    32'hBAD2, 32'h33,   32'h11,  1'b0};
    tbl[8] = '{mk(0, 13, 13, 0, 14, 'h33), 1'b1, 5'd13, 32'h9999, 32'h1313, 32'h1313, 32'h1313, 1'b0};
    tbl[9] = '{mk(0, 13, 0, 0, 15, 'h33), 1'b1, 5'd0,  32'h5,    32'hF9,   32'h0,    32'h9999, 1'b0};

    #3;
    chk("rst_valid", {31'd0, ID_VALID}, 32'd0);
    chk("rst_pc",    ID_PC,    32'd0);
    chk("rst_instr", ID_INSTR, 32'd0);
    chk("rst_rs1",   ID_RS1,   32'd0);
    chk("rst_rs2",   ID_RS2,   32'd0);
    chk("rst_ill",   {31'd0, ID_ILL}, 32'd0);
    chk("rst_haz",   {16'd0, HAZ_CNT}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    tag = "init";
    wb_only(5'd1, 32'h11);
    wb_only(5'd2, 32'h22);
    wb_only(5'd3, 32'h33);
    wb_only(5'd5, 32'h55);
    wb_only(5'd7, 32'h70);
    wb_only(5'd10, 32'hAA);

    tag = "table";
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, tbl[i].instr, 1'b1, 1'b0, tbl[i].we, tbl[i].wrd, tbl[i].wdat, tbl[i].fwd,
           1'b1, 1'b1, tbl[i].e1, tbl[i].e2, tbl[i].eill);
    end
    tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    tag = "load_use";
    tick(1'b1, mk(0, 0, 1, 2, 3, 'h03), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h11, 32'h0, 1'b0);
    tick(1'b1, mk(0, 2, 3, 0, 4, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'hBAD, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("haz_cnt1", {16'd0, HAZ_CNT}, 32'd1);
    tick(1'b1, mk(0, 2, 3, 0, 4, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'hBAD, 1'b1, 1'b1, 32'h33, 32'h222, 1'b0);
    tick(1'b1, mk(0, 0, 1, 2, 3, 'h03), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h11, 32'h0, 1'b0);
    tick(1'b1, mk(0, 0, 3, 0, 3, 'h37), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    chk("haz_cnt_lui", {16'd0, HAZ_CNT}, 32'd1);

    tag = "backpressure";
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, mk(0, 2, 1, 0, 6, 'h33), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    end
    tick(1'b1, mk(0, 2, 1, 0, 6, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h11, 32'h222, 1'b0);

    tag = "flush";
    tick(1'b1, mk(0, 0, 2, 2, 5, 'h03), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h222, 32'h0, 1'b0);
    tick(1'b1, mk(0, 1, 5, 0, 8, 'h33), 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("haz_cnt_flush", {16'd0, HAZ_CNT}, 32'd1);
    tick(1'b1, mk(0, 1, 5, 0, 8, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h55, 32'h11, 1'b0);

    tag = "hazards";
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, mk(0, 0, 1, 2, 3, 'h03), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h11, 32'h0, 1'b0);
      tick(1'b1, mk(0, 2, 3, 0, 4, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tick(1'b1, mk(0, 2, 3, 0, 4, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h33, 32'h222, 1'b0);
    end
    chk("haz_cnt5", {16'd0, HAZ_CNT}, 32'd5);
    chk("haz_sat_cntw2", {30'd0, haz1}, 32'd3);

    tag = "reset_mid";
    RST = 1'b1; WB_WE = 1'b1; WB_RD = 5'd3; WB_DATA = 32'hBAD;
    #1;
    chk("async_valid", {31'd0, ID_VALID}, 32'd0);
    chk("async_haz",   {16'd0, HAZ_CNT}, 32'd0);
    chk("async_haz16", {30'd0, haz1}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; WB_WE = 1'b0;
    q.delete();
    tick(1'b1, mk(0, 2, 3, 0, 4, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h33, 32'h222, 1'b0);

    tag = "nreg16";
    wb_only(5'd20, 32'h2020);
    wb_only(5'd17, 32'hDEAD);
    tick(1'b1, mk(0, 20, 1, 0, 17, 'h33), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h11, 32'h2020, 1'b0);
    chk("n16_valid", {31'd0, vld1}, 32'd1);
    chk("n16_ill",   {31'd0, ill1}, 32'd1);
    chk("n16_rs2",   rs2_1, 32'd0);
    chk("n16_rs1",   rs1_1, 32'h11);
    tick(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
